speed_loop: RTL



---
 rtl/speed_loop_pkg.sv | 20 ++
 rtl/sat_clamp.sv | 27 ++
 rtl/speed_loop.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/speed_loop_pkg.sv
// Shared types and fixed-point widths for the speed control loop.
package speed_loop_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DIFF,
    MUL,
    ACC,
    OUT
  } state_t;

  localparam int Q_SHIFT = 16;
  localparam int PHI_W   = 12;
  localparam int DATA_W  = 16;
  localparam int ERR_W   = 17;
  localparam int PROD_W  = 42;
  localparam int INTEG_W = 32;
  localparam int SUM_W   = 43;

endpackage

// File: rtl/sat_clamp.sv
// Symmetric saturating narrow: clamps a wide signed value to +/-limit.
module sat_clamp #(
  parameter int IN_W  = 43,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  din,
  input  logic signed [OUT_W-1:0] limit,
  output logic signed [OUT_W-1:0] dout
);

  logic signed [IN_W-1:0] lim_pos;
  logic signed [IN_W-1:0] lim_neg;

  // limit is always positive, so sign extension equals zero extension
  assign lim_pos = IN_W'(limit);
  assign lim_neg = -lim_pos;

  always_comb begin
    dout = din[OUT_W-1:0];
    if (din > lim_pos) begin
      dout = limit;
    end else if (din < lim_neg) begin
      dout = -limit;
    end
  end

endmodule

// File: rtl/speed_loop.sv
// Speed PI loop: per control tick, differentiates phi, runs a clamped PI
// controller and publishes speed and iq_aim with a one-cycle en_speed pulse.
module speed_loop
  import speed_loop_pkg::*;
#(
  parameter logic [23:0] SAMPLE_CYCLES = 24'd36864,
  parameter logic [23:0] Kp            = 24'd65536,
  parameter logic [23:0] Ki            = 24'd655,
  parameter logic [15:0] IQ_LIMIT      = 16'd400
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [PHI_W-1:0]         phi,
  input  logic signed [DATA_W-1:0] speed_aim,
  output logic                     en_speed,
  output logic signed [DATA_W-1:0] speed,
  output logic signed [DATA_W-1:0] iq_aim
);

  localparam logic signed [INTEG_W-1:0] INTEG_LIM = {IQ_LIMIT, 16'd0};
  localparam logic signed [DATA_W-1:0]  IQ_LIM    = IQ_LIMIT;

  logic [23:0]               cnt_reg;
  logic                      tick;
  state_t                    state_reg;
  state_t                    state_next;
  logic                      primed_reg;
  logic [PHI_W-1:0]          phi_prev_reg;
  logic [PHI_W-1:0]          phi_new_reg;
  logic signed [DATA_W-1:0]  aim_reg;
  logic signed [DATA_W-1:0]  speed_raw_reg;
  logic signed [ERR_W-1:0]   err_reg;
  logic signed [PROD_W-1:0]  p_reg;
  logic signed [PROD_W-1:0]  i_reg;
  logic signed [INTEG_W-1:0] integ_reg;
  logic signed [DATA_W-1:0]  speed_reg;
  logic signed [DATA_W-1:0]  iq_aim_reg;

  logic [PHI_W-1:0]          dphi;
  logic signed [DATA_W-1:0]  speed_raw_c;
  logic signed [ERR_W-1:0]   err_c;
  logic signed [PROD_W-1:0]  kp_s;
  logic signed [PROD_W-1:0]  ki_s;
  logic signed [PROD_W-1:0]  err_s;
  logic signed [PROD_W-1:0]  p_c;
  logic signed [PROD_W-1:0]  i_c;
  logic signed [SUM_W-1:0]   integ_sum;
  logic signed [INTEG_W-1:0] integ_next;
  logic signed [SUM_W-1:0]   sum_c;
  logic signed [SUM_W-1:0]   sum_q;
  logic signed [DATA_W-1:0]  iq_sat;

  assign tick = (cnt_reg == SAMPLE_CYCLES - 24'd1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_reg <= '0;
    end else if (tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 24'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // The very first tick only primes phi_prev, so the FSM stays idle
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (tick && primed_reg) state_next = DIFF;
      DIFF:    state_next = MUL;
      MUL:     state_next = ACC;
      ACC:     state_next = OUT;
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Modulo-4096 difference read back as signed 12-bit handles encoder wrap
  assign dphi        = phi_new_reg - phi_prev_reg;
  assign speed_raw_c = {{(DATA_W-PHI_W){dphi[PHI_W-1]}}, dphi};
  assign err_c       = {aim_reg[DATA_W-1], aim_reg} - {speed_raw_c[DATA_W-1], speed_raw_c};

  assign kp_s  = {{(PROD_W-24){1'b0}}, Kp};
  assign ki_s  = {{(PROD_W-24){1'b0}}, Ki};
  assign err_s = {{(PROD_W-ERR_W){err_reg[ERR_W-1]}}, err_reg};
  assign p_c   = kp_s * err_s;
  assign i_c   = ki_s * err_s;

  assign integ_sum = {{(SUM_W-INTEG_W){integ_reg[INTEG_W-1]}}, integ_reg}
                   + {i_reg[PROD_W-1], i_reg};

  sat_clamp #(
    .IN_W (SUM_W),
    .OUT_W(INTEG_W)
  ) u_integ_clamp (
    .din  (integ_sum),
    .limit(INTEG_LIM),
    .dout (integ_next)
  );

  assign sum_c = {p_reg[PROD_W-1], p_reg}
               + {{(SUM_W-INTEG_W){integ_next[INTEG_W-1]}}, integ_next};
  assign sum_q = sum_c >>> Q_SHIFT;

  sat_clamp #(
    .IN_W (SUM_W),
    .OUT_W(DATA_W)
  ) u_out_clamp (
    .din  (sum_q),
    .limit(IQ_LIM),
    .dout (iq_sat)
  );

  // Outputs are loaded on the edge entering OUT so they are valid with en_speed
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      primed_reg    <= 1'b0;
      phi_prev_reg  <= '0;
      phi_new_reg   <= '0;
      aim_reg       <= '0;
      speed_raw_reg <= '0;
      err_reg       <= '0;
      p_reg         <= '0;
      i_reg         <= '0;
      integ_reg     <= '0;
      speed_reg     <= '0;
      iq_aim_reg    <= '0;
    end else begin
      if (tick && state_reg == IDLE) begin
        phi_new_reg <= phi;
        aim_reg     <= speed_aim;
        if (!primed_reg) begin
          phi_prev_reg <= phi;
          primed_reg   <= 1'b1;
        end
      end
      case (state_reg)
        DIFF: begin
          speed_raw_reg <= speed_raw_c;
          err_reg       <= err_c;
          phi_prev_reg  <= phi_new_reg;
        end
        MUL: begin
          p_reg <= p_c;
          i_reg <= i_c;
        end
        ACC: begin
          integ_reg  <= integ_next;
          speed_reg  <= speed_raw_reg;
          iq_aim_reg <= iq_sat;
        end
        default: ;
      endcase
    end
  end

  assign en_speed = (state_reg == OUT);
  assign speed    = speed_reg;
  assign iq_aim   = iq_aim_reg;

endmodule
